// File: rtl/mio_pkg.sv
// Shared types and constants for the MIO bus arbiter: FSM state encoding,
// grant codes and the read data returned when an access times out.
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC_CPU = 2'd1,
        ST_ACC_DMA = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Grant codes double as the one-hot request/pick vector {dma, cpu}
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DMA  = 2'b10
    } grant_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    function automatic state_t acc_state_for(input grant_t g);
        return (g == GNT_DMA) ? ST_ACC_DMA : ST_ACC_CPU;
    endfunction

endpackage

// File: rtl/mio_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, and on a tie
// the requester that did not win last time is chosen.
module rr_arb2
    import mio_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic [1:0] pick
);

    always_comb begin
        pick = GNT_NONE;
        case (req)
            2'b01:   pick = GNT_CPU;
            2'b10:   pick = GNT_DMA;
            2'b11:   pick = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
            default: pick = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mio_arbiter.sv
// Serialises CPU and DMA accesses onto the single MIO bus with round-robin
// fairness, a per-access ack timeout and a one-cycle bus-idle gap between accesses.
module mio_arbiter
    import mio_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    grant_t            grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              dma_ready_q, dma_ready_d;
    logic              timeout_err_q, timeout_err_d;

    logic [1:0]        pick;
    logic              in_access;
    logic              owner_cpu;
    logic              acked;
    logic              timed_out;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .req        ({dma_req, cpu_req}),
        .last_grant (last_grant_q),
        .pick       (pick)
    );

    assign in_access = (state_q == ST_ACC_CPU) || (state_q == ST_ACC_DMA);
    assign owner_cpu = (state_q == ST_ACC_CPU);
    assign acked     = in_access && mem_req_q && mem_ack;
    assign timed_out = in_access && !acked && (cnt_q == CNT_LAST);
    assign resp_data = acked ? mem_rdata : DATA_W'(TIMEOUT_RDATA);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        cpu_ready_d   = 1'b0;
        dma_ready_d   = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick != GNT_NONE) begin
                    state_d      = acc_state_for(grant_t'(pick));
                    grant_d      = grant_t'(pick);
                    last_grant_d = grant_t'(pick);
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    // The winner's command is captured once and held for the whole access
                    if (pick == GNT_CPU) begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end else begin
                        mem_we_d    = dma_we;
                        mem_addr_d  = dma_addr;
                        mem_wdata_d = dma_wdata;
                    end
                end
            end

            ST_ACC_CPU, ST_ACC_DMA: begin
                if (acked || timed_out) begin
                    state_d   = ST_DONE;
                    grant_d   = GNT_NONE;
                    mem_req_d = 1'b0;
                    if (timed_out) begin
                        timeout_err_d = 1'b1;
                    end
                    // Writes leave the requester's read data register untouched
                    if (owner_cpu) begin
                        cpu_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            cpu_rdata_d = resp_data;
                        end
                    end else begin
                        dma_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            dma_rdata_d = resp_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                grant_d   = GNT_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GNT_DMA;
            grant_q       <= GNT_NONE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
            cpu_ready_q   <= 1'b0;
            dma_ready_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
            cpu_ready_q   <= cpu_ready_d;
            dma_ready_q   <= dma_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ready   = cpu_ready_q;
    assign dma_rdata   = dma_rdata_q;
    assign dma_ready   = dma_ready_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter: reset, single accesses, round-robin ties,
// frozen bus command, ack timeout and asynchronous reset mid-access.
module tb_mio_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks;
    int failures;

    mio_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_rdata   (dma_rdata),
        .dma_ready   (dma_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0; mem_ack = 0;
        #3;
        checks++;
        if ({grant, mem_req, mem_we, cpu_ready, dma_ready, timeout_err} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                     {grant, mem_req, mem_we, cpu_ready, dma_ready, timeout_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0",
                     {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Both requesters hold their request continuously: CPU, DMA, CPU, then a fresh tie picks DMA
    task automatic test_round_robin();
        mem_ack = 1'b1;
        mem_rdata = 32'hC0DE_0001;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0100;
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0200;
        tick();
        checks++;
        if ({grant, mem_req, mem_addr} !== {2'b01, 1'b1, 32'h0000_0100}) begin
            failures++;
            $display("[TB] FAIL rr_first_cpu: grant/req/addr %b/%b/%h expected 01/1/00000100", grant, mem_req, mem_addr);
        end
        tick();
        checks++;
        if ({cpu_ready, dma_ready, grant, mem_req, cpu_rdata} !== {1'b1, 1'b0, 2'b00, 1'b0, 32'hC0DE_0001}) begin
            failures++;
            $display("[TB] FAIL rr_cpu_done: cr/dr/grant/req/rdata %b/%b/%b/%b/%h expected 1/0/00/0/c0de0001",
                     cpu_ready, dma_ready, grant, mem_req, cpu_rdata);
        end
        tick();
        checks++;
        if ({cpu_ready, grant, mem_req} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rr_gap: cr/grant/req %b/%b/%b expected 0/00/0", cpu_ready, grant, mem_req);
        end
        tick();
        checks++;
        if ({grant, mem_req, mem_addr} !== {2'b10, 1'b1, 32'h0000_0200}) begin
            failures++;
            $display("[TB] FAIL rr_second_dma: grant/req/addr %b/%b/%h expected 10/1/00000200", grant, mem_req, mem_addr);
        end
        tick();
        checks++;
        if ({dma_ready, cpu_ready, dma_rdata} !== {1'b1, 1'b0, 32'hC0DE_0001}) begin
            failures++;
            $display("[TB] FAIL rr_dma_done: dr/cr/rdata %b/%b/%h expected 1/0/c0de0001", dma_ready, cpu_ready, dma_rdata);
        end
        tick();
        tick();
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rr_third_cpu: grant %b expected 01", grant);
        end
        cpu_req = 0; dma_req = 0;
        tick();
        tick();
        cpu_req = 1; dma_req = 1;
        tick();
        checks++;
        if ({grant, mem_addr} !== {2'b10, 32'h0000_0200}) begin
            failures++;
            $display("[TB] FAIL rr_new_pair_dma: grant/addr %b/%h expected 10/00000200", grant, mem_addr);
        end
        cpu_req = 0; dma_req = 0;
        tick();
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010; cpu_wdata = 32'h5555_5555;
        tick();
        checks++;
        if ({mem_req, mem_we, grant, mem_addr, cpu_ready} !== {1'b1, 1'b0, 2'b01, 32'h0000_0010, 1'b0}) begin
            failures++;
            $display("[TB] FAIL cpu_rd_issue: req/we/grant/addr/cr %b/%b/%b/%h/%b expected 1/0/01/00000010/0",
                     mem_req, mem_we, grant, mem_addr, cpu_ready);
        end
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        checks++;
        if ({cpu_ready, dma_ready, mem_req, cpu_rdata} !== {1'b1, 1'b0, 1'b0, 32'h1234_5678}) begin
            failures++;
            $display("[TB] FAIL cpu_rd_done: cr/dr/req/rdata %b/%b/%b/%h expected 1/0/0/12345678",
                     cpu_ready, dma_ready, mem_req, cpu_rdata);
        end
        cpu_req = 0; mem_ack = 0;
        tick();
        checks++;
        if ({cpu_ready, dma_ready, cpu_rdata} !== {2'b00, 32'h1234_5678}) begin
            failures++;
            $display("[TB] FAIL cpu_rd_pulse: cr/dr/rdata %b/%b/%h expected 0/0/12345678", cpu_ready, dma_ready, cpu_rdata);
        end
    endtask

    task automatic test_dma_write_frozen();
        dma_req = 1; dma_we = 1; dma_addr = 32'h8000_0004; dma_wdata = 32'hA5A5_A5A5;
        tick();
        checks++;
        if ({grant, mem_we, mem_addr, mem_wdata} !== {2'b10, 1'b1, 32'h8000_0004, 32'hA5A5_A5A5}) begin
            failures++;
            $display("[TB] FAIL dma_wr_issue: grant/we/addr/wdata %b/%b/%h/%h expected 10/1/80000004/a5a5a5a5",
                     grant, mem_we, mem_addr, mem_wdata);
        end
        dma_addr = 32'h0000_1234; dma_wdata = 32'h0000_0000; dma_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040;
        tick();
        tick();
        checks++;
        if ({grant, mem_we, mem_addr, mem_wdata, cpu_ready} !== {2'b10, 1'b1, 32'h8000_0004, 32'hA5A5_A5A5, 1'b0}) begin
            failures++;
            $display("[TB] FAIL dma_wr_frozen: grant/we/addr/wdata/cr %b/%b/%h/%h/%b expected 10/1/80000004/a5a5a5a5/0",
                     grant, mem_we, mem_addr, mem_wdata, cpu_ready);
        end
        mem_ack = 1; mem_rdata = 32'hFFFF_0000;
        tick();
        checks++;
        if ({dma_ready, dma_rdata} !== {1'b1, 32'hC0DE_0001}) begin
            failures++;
            $display("[TB] FAIL dma_wr_done: dr/rdata %b/%h expected 1/c0de0001", dma_ready, dma_rdata);
        end
        dma_req = 0; mem_ack = 0;
        tick();
        checks++;
        if ({grant, mem_req} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL dma_wr_gap: grant/req %b/%b expected 00/0", grant, mem_req);
        end
        tick();
        checks++;
        if ({grant, mem_we, mem_addr} !== {2'b01, 1'b0, 32'h0000_0040}) begin
            failures++;
            $display("[TB] FAIL cpu_after_dma: grant/we/addr %b/%b/%h expected 01/0/00000040", grant, mem_we, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        cpu_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_timeout();
        int hi_cycles;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0300;
        mem_ack = 0;
        tick();
        checks++;
        if ({mem_req, timeout_err} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL to_start: req/err %b/%b expected 1/0", mem_req, timeout_err);
        end
        hi_cycles = 0;
        for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
            hi_cycles++;
            tick();
        end
        checks++;
        if (hi_cycles !== 15) begin
            failures++;
            $display("[TB] FAIL to_req_cycles: got %0d expected 15", hi_cycles);
        end
        checks++;
        if ({mem_req, cpu_ready, grant, timeout_err, cpu_rdata} !== {1'b0, 1'b1, 2'b00, 1'b1, 32'hDEAD_BEEF}) begin
            failures++;
            $display("[TB] FAIL to_abort: req/cr/grant/err/rdata %b/%b/%b/%b/%h expected 0/1/00/1/deadbeef",
                     mem_req, cpu_ready, grant, timeout_err, cpu_rdata);
        end
        cpu_req = 0;
        tick();
        tick();
        dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0500; dma_wdata = 32'h0000_0077;
        tick();
        mem_ack = 1;
        tick();
        checks++;
        if ({dma_ready, timeout_err, cpu_ready} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL to_sticky: dr/err/cr %b/%b/%b expected 1/1/0", dma_ready, timeout_err, cpu_ready);
        end
        dma_req = 0; mem_ack = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_access();
        int ready_seen;
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0600;
        tick();
        checks++;
        if ({grant, mem_req} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL rst_mid_pre: grant/req %b/%b expected 10/1", grant, mem_req);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, grant, dma_ready, timeout_err} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_async: req/grant/dr/err %b/%b/%b/%b expected 0/00/0/0",
                     mem_req, grant, dma_ready, timeout_err);
        end
        dma_req = 0;
        mem_ack = 1;
        tick();
        reset = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dma_ready === 1'b1 || cpu_ready === 1'b1) ready_seen++;
        end
        checks++;
        if (ready_seen !== 0) begin
            failures++;
            $display("[TB] FAIL rst_no_ready: got %0d ready cycles expected 0", ready_seen);
        end
        cpu_req = 1; cpu_addr = 32'h0000_0700;
        dma_req = 1; dma_addr = 32'h0000_0800;
        tick();
        checks++;
        if ({grant, mem_addr} !== {2'b01, 32'h0000_0700}) begin
            failures++;
            $display("[TB] FAIL rst_tie_cpu: grant/addr %b/%h expected 01/00000700", grant, mem_addr);
        end
        cpu_req = 0; dma_req = 0;
        tick();
        mem_ack = 0;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_round_robin();
        test_cpu_read();
        test_dma_write_frozen();
        test_timeout();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
